pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage core (pc_reg / if_id / id_ex / ex).
- Consumes the EX-stage redirect (jump_en/jump_addr) and multi-cycle busy (hold_flag).
- Consumes an external debug halt request.
- Drives the PC redirect, bubble-insertion (flush) and per-register hold controls.
- Mealy FSM: responds in the same cycle, then extends the flush or holds the pipeline over subsequent cycles.

Parameters:
- FLUSH_CYCLES, 2: total cycles flush_o stays high per redirect (covers the redirect cycle plus 1-cycle instruction ROM latency); legal range 1..15.
- MAX_STALL, 1024: consecutive cycles of hold_flag_ex_i after which stall_timeout_o sets; legal range 1..65535.
- STALL_CNT_W, 16: stall counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- jump_en_i  in  1  redirect request from ex
- jump_addr_i  in  32  redirect target from ex
- hold_flag_ex_i  in  1  ex busy with a multi-cycle op
- halt_req_i  in  1  debug halt request (level)
- jump_en_o  out  1  redirect strobe to pc_reg
- jump_addr_o  out  32  redirect target to pc_reg
- flush_o  out  1  load NOP into if_id and id_ex
- hold_pc_o  out  1  freeze pc_reg
- hold_if_id_o  out  1  freeze if_id
- hold_id_ex_o  out  1  freeze id_ex
- halted_o  out  1  core halted
- stall_timeout_o  out  1  sticky stall watchdog flag

Behaviour:
- Reset: rst sampled low at posedge sets state=RUN, flush_cnt=0, stall_cnt=0, stall_timeout_o=0. While rst is low, all outputs are forced 0 (jump_addr_o=32'h0).
- States: RUN, FLUSH, STALL, HALT. Outputs are combinational from state and inputs. Only the state, counters and stall_timeout_o are registered.
- Input priority in RUN: hold_flag_ex_i > jump_en_i > halt_req_i.
- RUN:
  - hold_flag_ex_i=1: hold_pc/if_id/id_ex=1 this cycle; jump_en_o=0 (jump ignored); stall_cnt<=1; next STALL.
  - else jump_en_i=1: jump_en_o=1, jump_addr_o=jump_addr_i, flush_o=1. If FLUSH_CYCLES>1: flush_cnt<=FLUSH_CYCLES-1, next FLUSH; otherwise stay RUN.
  - else halt_req_i=1: hold_pc/if_id/id_ex=1; next HALT.
  - else all outputs 0.
- FLUSH:
  - flush_o=1 and jump_en_o=0 unless a new jump arrives; flush_cnt decrements each cycle; exit to RUN after the cycle in which flush_cnt==1.
  - A new jump_en_i in FLUSH is forwarded (jump_en_o=1, jump_addr_o=jump_addr_i) and flush_cnt reloads to FLUSH_CYCLES-1.
  - hold_flag_ex_i and halt_req_i are ignored in FLUSH; halt is taken in RUN afterwards.
- STALL:
  - Holds all three pipeline registers while hold_flag_ex_i=1; stall_cnt increments, saturating at all-ones.
  - When stall_cnt==MAX_STALL, stall_timeout_o<=1, sticky until reset.
  - hold_flag_ex_i=0: holds released in the same cycle; jump_en_i in that cycle is handled as in RUN (forward, flush, go to FLUSH or RUN); stall_cnt<=0.
- HALT:
  - All holds=1, flush_o=0, halted_o=1 (halted_o is 1 only in HALT).
  - Exit to RUN on the cycle after halt_req_i is sampled 0. Holds remain asserted on that sampling cycle and release in RUN.
  - jump_en_i and hold_flag_ex_i are ignored (EX is frozen).
- Mid-operation reset: any state or count is abandoned; state returns to RUN on the next edge; the sticky flag clears.
- The flush counter width must hold FLUSH_CYCLES. The stall compare is zero-extended to STALL_CNT_W.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all inputs 1 -> every output 0. Release -> state RUN, stall_timeout_o=0.
- Redirect: jump_en_i=1, jump_addr_i=32'h0000_0040 for one cycle, FLUSH_CYCLES=2 -> jump_en_o=1 and jump_addr_o=32'h40 in that cycle; flush_o=1 for exactly 2 cycles; then all 0.
- Back-to-back jumps: second jump_en_i (addr 32'h80) on the flush-extension cycle -> forwarded with addr 32'h80; flush_o stays high 2 more cycles (3 total).
- Multi-cycle stall: hold_flag_ex_i=1 for 5 cycles with jump_en_i=1 throughout -> holds=1 for 5 cycles, jump_en_o=0. On the first cycle with hold=0 -> jump_en_o=1, flush begins.
- Watchdog: MAX_STALL=4, hold_flag_ex_i=1 for 6 cycles -> stall_timeout_o rises after the 4th stall cycle and remains 1 after the stall ends, until rst=0.
- Halt: halt_req_i=1 during a flush -> HALT entered only after flush_o drops; halted_o=1 and holds=1. Drop halt_req_i -> halted_o=0 and holds=0 one cycle later.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns EX redirects, EX multi-cycle busy and
// debug halt requests into PC redirect, flush (bubble) and per-register holds.
// Mealy outputs react in the same cycle; the FSM extends flushes and holds.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,    // total flush cycles per redirect, 1..15
   parameter int unsigned MAX_STALL    = 1024, // stall cycles before the watchdog trips
   parameter int unsigned STALL_CNT_W  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_ex_i,
   input  logic        halt_req_i,
   output logic        jump_en_o,
   output logic [31:0] jump_addr_o,
   output logic        flush_o,
   output logic        hold_pc_o,
   output logic        hold_if_id_o,
   output logic        hold_id_ex_o,
   output logic        halted_o,
   output logic        stall_timeout_o
);

   localparam int unsigned FlushCntW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FlushCntW-1:0]   FlushReload = FlushCntW'(FLUSH_CYCLES - 1);
   localparam logic [FlushCntW-1:0]   FlushOne    = FlushCntW'(1);
   localparam logic [STALL_CNT_W-1:0] MaxStallCnt = STALL_CNT_W'(MAX_STALL);
   localparam logic [STALL_CNT_W-1:0] StallOne    = STALL_CNT_W'(1);
   localparam logic [STALL_CNT_W-1:0] StallSat    = '1;
   localparam bit                     MultiFlush  = (FLUSH_CYCLES > 1);

   typedef enum logic [1:0] {StRun, StFlush, StStall, StHalt} state_e;

   state_e                 state_q, state_d;
   logic [FlushCntW-1:0]   flush_cnt_q, flush_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   timeout_q, timeout_d;

   logic        take_jump;
   logic        stall_hold;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        flush;
   logic        hold;
   logic        halted;

   // State, counters and sticky watchdog flag; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StRun;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state and Mealy outputs.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      stall_cnt_d = stall_cnt_q;
      timeout_d   = timeout_q;
      take_jump   = 1'b0;
      stall_hold  = 1'b0;
      jump_en     = 1'b0;
      jump_addr   = 32'h0;
      flush       = 1'b0;
      hold        = 1'b0;
      halted      = 1'b0;

      unique case (state_q)
         StRun: begin
            // Priority: EX busy, then redirect, then debug halt.
            if (hold_flag_ex_i) begin
               hold        = 1'b1;
               stall_hold  = 1'b1;
               stall_cnt_d = StallOne;
               state_d     = StStall;
            end else if (jump_en_i) begin
               take_jump = 1'b1;
            end else if (halt_req_i) begin
               hold    = 1'b1;
               state_d = StHalt;
            end
         end
         StFlush: begin
            // Busy and halt wait until the flush has drained.
            flush = 1'b1;
            if (jump_en_i) begin
               take_jump = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q - FlushOne;
               if (flush_cnt_q <= FlushOne) begin
                  state_d = StRun;
               end
            end
         end
         StStall: begin
            if (hold_flag_ex_i) begin
               hold       = 1'b1;
               stall_hold = 1'b1;
               if (stall_cnt_q != StallSat) begin
                  stall_cnt_d = stall_cnt_q + StallOne;
               end
            end else begin
               // Release in the same cycle; a pending redirect is taken now,
               // a halt request is picked up from RUN on the next cycle.
               stall_cnt_d = '0;
               state_d     = StRun;
               take_jump   = jump_en_i;
            end
         end
         StHalt: begin
            // EX is frozen, so redirects and busy are ignored here.
            hold   = 1'b1;
            halted = 1'b1;
            if (!halt_req_i) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
         end
      endcase

      if (take_jump) begin
         jump_en   = 1'b1;
         jump_addr = jump_addr_i;
         flush     = 1'b1;
         if (MultiFlush) begin
            flush_cnt_d = FlushReload;
            state_d     = StFlush;
         end else begin
            flush_cnt_d = '0;
            state_d     = StRun;
         end
      end

      // Trip on the cycle the accepted stall run reaches MAX_STALL.
      if (stall_hold && (stall_cnt_d == MaxStallCnt)) begin
         timeout_d = 1'b1;
      end
   end

   // Every output is forced low while reset is asserted.
   always_comb begin
      jump_en_o       = rst & jump_en;
      jump_addr_o     = rst ? jump_addr : 32'h0;
      flush_o         = rst & flush;
      hold_pc_o       = rst & hold;
      hold_if_id_o    = rst & hold;
      hold_id_ex_o    = rst & hold;
      halted_o        = rst & halted;
      stall_timeout_o = rst & timeout_q;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process drives inputs after each
// rising edge and queues the expected outputs from a behavioural model; the
// monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

   localparam int unsigned FC = 2;
   localparam int unsigned MS = 4;
   localparam int unsigned SW = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        jump_en_i = 1'b1;
   logic [31:0] jump_addr_i = 32'hffff_ffff;
   logic        hold_flag_ex_i = 1'b1;
   logic        halt_req_i = 1'b1;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        flush_o;
   logic        hold_pc_o;
   logic        hold_if_id_o;
   logic        hold_id_ex_o;
   logic        halted_o;
   logic        stall_timeout_o;

   typedef struct packed {
      logic        jump_en;
      logic [31:0] addr;
      logic        flush;
      logic        hold_pc;
      logic        hold_if_id;
      logic        hold_id_ex;
      logic        halted;
      logic        timeout;
   } out_t;

   out_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Model: remaining flush-extension cycles, halted flag, length of the
   // accepted busy run, sticky watchdog.
   int m_flush_left = 0;
   bit m_halted     = 1'b0;
   int m_stall_run  = 0;
   bit m_timeout    = 1'b0;

   pipe_ctrl #(
      .FLUSH_CYCLES(FC),
      .MAX_STALL   (MS),
      .STALL_CNT_W (SW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .jump_en_i      (jump_en_i),
      .jump_addr_i    (jump_addr_i),
      .hold_flag_ex_i (hold_flag_ex_i),
      .halt_req_i     (halt_req_i),
      .jump_en_o      (jump_en_o),
      .jump_addr_o    (jump_addr_o),
      .flush_o        (flush_o),
      .hold_pc_o      (hold_pc_o),
      .hold_if_id_o   (hold_if_id_o),
      .hold_id_ex_o   (hold_id_ex_o),
      .halted_o       (halted_o),
      .stall_timeout_o(stall_timeout_o)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus plus its expected response.
   task automatic step(input logic r, input logic j, input logic [31:0] a,
                       input logic h, input logic hq);
      out_t e;
      @(posedge clk);
      #1;
      rst            = r;
      jump_en_i      = j;
      jump_addr_i    = a;
      hold_flag_ex_i = h;
      halt_req_i     = hq;
      e = '0;
      if (!r) begin
         m_flush_left = 0;
         m_halted     = 1'b0;
         m_stall_run  = 0;
         m_timeout    = 1'b0;
      end else begin
         e.timeout = m_timeout;
         if (m_halted) begin
            e.hold_pc = 1'b1; e.hold_if_id = 1'b1; e.hold_id_ex = 1'b1;
            e.halted  = 1'b1;
            if (!hq) m_halted = 1'b0;
         end else if (m_flush_left > 0) begin
            e.flush = 1'b1;
            if (j) begin
               e.jump_en = 1'b1; e.addr = a;
               m_flush_left = FC - 1;
            end else begin
               m_flush_left--;
            end
         end else if (h) begin
            e.hold_pc = 1'b1; e.hold_if_id = 1'b1; e.hold_id_ex = 1'b1;
            if (m_stall_run < (1 << SW) - 1) m_stall_run++;
            if (m_stall_run == MS) m_timeout = 1'b1;
         end else if (j) begin
            e.jump_en = 1'b1; e.addr = a; e.flush = 1'b1;
            m_flush_left = FC - 1;
            m_stall_run  = 0;
         end else if (hq && m_stall_run == 0) begin
            e.hold_pc = 1'b1; e.hold_if_id = 1'b1; e.hold_id_ex = 1'b1;
            m_halted = 1'b1;
         end else begin
            m_stall_run = 0;
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   out_t m_exp, m_act;
   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() > 0) begin
         m_exp = exp_q.pop_front();
         m_act = '{jump_en_o, jump_addr_o, flush_o, hold_pc_o, hold_if_id_o,
                   hold_id_ex_o, halted_o, stall_timeout_o};
         n_tests++;
         if (m_act !== m_exp) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got jen=%b addr=%h fl=%b h=%b%b%b hlt=%b to=%b, expected jen=%b addr=%h fl=%b h=%b%b%b hlt=%b to=%b",
                     cyc, m_act.jump_en, m_act.addr, m_act.flush, m_act.hold_pc,
                     m_act.hold_if_id, m_act.hold_id_ex, m_act.halted, m_act.timeout,
                     m_exp.jump_en, m_exp.addr, m_exp.flush, m_exp.hold_pc,
                     m_exp.hold_if_id, m_exp.hold_id_ex, m_exp.halted, m_exp.timeout);
         end
      end
   end

   initial begin
      logic r_rand;
      int   hold_left;
      int   halt_left;
      hold_left = 0;
      halt_left = 0;

      // Reset held with every input high.
      repeat (3) step(1'b0, 1'b1, 32'hffff_ffff, 1'b1, 1'b1);
      repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Single redirect.
      step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Back-to-back redirects.
      step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Stall with a redirect pending throughout.
      repeat (5) step(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
      step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Watchdog: sticky past the stall, cleared by reset.
      repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Halt requested during a flush.
      step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

      // Randomized traffic with busy and halt runs and occasional resets.
      repeat (800) begin
         r_rand = ($urandom_range(0, 99) >= 2);
         if (hold_left == 0 && $urandom_range(0, 9) == 0) hold_left = $urandom_range(1, 7);
         if (halt_left == 0 && $urandom_range(0, 14) == 0) halt_left = $urandom_range(1, 5);
         step(r_rand, ($urandom_range(0, 99) < 30), $urandom, (hold_left > 0), (halt_left > 0));
         if (hold_left > 0) hold_left--;
         if (halt_left > 0) halt_left--;
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
